muldiv_ctrl: RTL and testbench

Multi-cycle multiply/divide sequencer serving the EXE stage of the 5-stage pipeline. Accepts MULT/MULTU/DIV/DIVU operands from EXE, runs a 32-iteration shift-add multiplier or restoring divider, and holds the 64-bit HI/LO result until the pipeline consumes it. EXE stalls on `busy`, so `EXE_over = EXE_valid & (~(multiply|divide) | done)`.

---
 rtl/muldiv_pkg.sv | 15 +
 rtl/muldiv_ctrl_if.sv | 26 ++
 rtl/muldiv_signfix.sv | 26 ++
 rtl/muldiv_ctrl.sv | 162 ++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared state type and constants for the multiply/divide sequencer
package muldiv_pkg;

  localparam int MULDIV_ITER = 32;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_ctrl_if.sv
// rtl/muldiv_ctrl_if.sv - EXE-side request/result bundle of the multiply/divide sequencer
interface muldiv_ctrl_if #(
  parameter int WIDTH = muldiv_pkg::MULDIV_ITER
);
  logic             start;
  logic             op_div;
  logic             sign_op;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic             ack;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op_div, sign_op, src1, src2, ack, cancel,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op_div, sign_op, src1, src2, ack, cancel,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_signfix.sv
// rtl/muldiv_signfix.sv - conditional two's complement of a 64-bit value or of its two halves
module muldiv_signfix #(
  parameter int W = 32
) (
  input  logic           wide,
  input  logic           neg_hi,
  input  logic           neg_lo,
  input  logic [2*W-1:0] din,
  output logic [2*W-1:0] dout
);
  logic [2*W-1:0] neg_full;
  logic [W-1:0]   neg_h;
  logic [W-1:0]   neg_l;

  // wide mode negates the whole product on neg_hi; otherwise each half is handled on its own
  always_comb begin
    neg_full = -din;
    neg_h    = -din[2*W-1:W];
    neg_l    = -din[W-1:0];
    if (wide) begin
      dout = neg_hi ? neg_full : din;
    end else begin
      dout = {(neg_hi ? neg_h : din[2*W-1:W]), (neg_lo ? neg_l : din[W-1:0])};
    end
  end
endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - multi-cycle shift-add multiplier / restoring divider for the EXE stage
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_ITER
) (
  input logic          clk,
  input logic          reset,
  muldiv_ctrl_if.slave bus
);
  localparam int               CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  muldiv_state_e      state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               op_q, op_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dz_q, dz_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;

  logic [2*WIDTH-1:0] abs_ops;
  logic [2*WIDTH-1:0] step;
  logic [2*WIDTH-1:0] fixed;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_part;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;

  muldiv_signfix #(.W(WIDTH)) u_abs (
    .wide   (1'b0),
    .neg_hi (bus.sign_op & bus.src1[WIDTH-1]),
    .neg_lo (bus.sign_op & bus.src2[WIDTH-1]),
    .din    ({bus.src1, bus.src2}),
    .dout   (abs_ops)
  );

  // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    div_part = acc_q[2*WIDTH-1:WIDTH-1];
    div_ge   = div_part >= {1'b0, b_q};
    div_diff = div_part[WIDTH-1:0] - b_q;
    if (op_q == OP_DIV) begin
      step = {(div_ge ? div_diff : div_part[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
    end else begin
      step = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  muldiv_signfix #(.W(WIDTH)) u_fix (
    .wide   (op_q == OP_MUL),
    .neg_hi ((op_q == OP_DIV) ? neg_rem_q : neg_quo_q),
    .neg_lo (neg_quo_q),
    .din    (step),
    .dout   (fixed)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    busy_d    = busy_q;
    done_d    = done_q;
    b_d       = b_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    acc_d     = acc_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          op_d      = bus.op_div;
          neg_quo_d = bus.sign_op & (bus.src1[WIDTH-1] ^ bus.src2[WIDTH-1]);
          neg_rem_d = bus.sign_op & bus.src1[WIDTH-1];
          dz_d      = (bus.src2 == '0);
          acc_d     = {{WIDTH{1'b0}}, abs_ops[2*WIDTH-1:WIDTH]};
          b_d       = abs_ops[WIDTH-1:0];
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = ST_CALC;
        end
      end
      ST_CALC: begin
        acc_d = step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          // A zero divisor leaves the dividend as remainder, so only the quotient needs forcing
          hi_d    = fixed[2*WIDTH-1:WIDTH];
          lo_d    = (op_q == OP_DIV && dz_q) ? '1 : fixed[WIDTH-1:0];
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.ack) begin
          done_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    if (bus.cancel) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= OP_MUL;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      acc_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      b_q       <= b_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      acc_q     <= acc_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - directed bench for muldiv_ctrl with an arithmetic reference model
module tb_muldiv_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  muldiv_ctrl_if #(.WIDTH(32)) bus ();

  muldiv_ctrl #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] expect_result(input logic dv, input logic sg,
                                                input logic [31:0] a, input logic [31:0] b);
    longint     sa, sb, q, r;
    logic [63:0] qv, rv;
    sa = sg ? longint'($signed(a)) : longint'(a);
    sb = sg ? longint'($signed(b)) : longint'(b);
    if (!dv) return 64'(sa * sb);
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    q  = sa / sb;
    r  = sa % sb;
    qv = 64'(q);
    rv = 64'(r);
    return {rv[31:0], qv[31:0]};
  endfunction

  // Reference: an accepted request completes 32 cycles later with the arithmetic result
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [63:0] m_pend = '0;
  int          m_left = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_left <= 0;
    end else if (bus.cancel) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_hi   <= m_pend[63:32];
        m_lo   <= m_pend[31:0];
      end
    end else if (m_done) begin
      if (bus.ack) m_done <= 1'b0;
    end else if (bus.start) begin
      m_pend <= expect_result(bus.op_div, bus.sign_op, bus.src1, bus.src2);
      m_busy <= 1'b1;
      m_left <= 32;
    end
  end

  always @(negedge clk) begin
    chk("model busy", 64'(bus.busy), 64'(m_busy));
    chk("model done", 64'(bus.done), 64'(m_done));
    chk("model hi", 64'(bus.hi), 64'(m_hi));
    chk("model lo", 64'(bus.lo), 64'(m_lo));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string name, input logic dv, input logic sg,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el);
    bus.start = 1'b1; bus.op_div = dv; bus.sign_op = sg; bus.src1 = a; bus.src2 = b;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      chk({name, " busy"}, 64'(bus.busy), 64'(1));
      chk({name, " early done"}, 64'(bus.done), 64'(0));
      tick();
    end
    chk({name, " done"}, 64'(bus.done), 64'(1));
    chk({name, " busy off"}, 64'(bus.busy), 64'(0));
    chk({name, " hi"}, 64'(bus.hi), 64'(eh));
    chk({name, " lo"}, 64'(bus.lo), 64'(el));
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    chk({name, " done cleared"}, 64'(bus.done), 64'(0));
  endtask

  initial begin
    bus.start = 1'b0; bus.op_div = 1'b0; bus.sign_op = 1'b0;
    bus.src1 = '0; bus.src2 = '0; bus.ack = 1'b0; bus.cancel = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    chk("reset busy", 64'(bus.busy), 64'(0));
    chk("reset done", 64'(bus.done), 64'(0));
    chk("reset hi", 64'(bus.hi), 64'(0));
    chk("reset lo", 64'(bus.lo), 64'(0));
    reset = 1'b0;
    tick();

    run_op("multu max", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult -3x7", 1'b0, 1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("mult min2", 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_op("mult x0", 1'b0, 1'b1, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
    run_op("divu 100/7", 1'b1, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("div -7/2", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div 7/-2", 1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("div ovf", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("divu by0", 1'b1, 1'b0, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF);
    run_op("div by0", 1'b1, 1'b1, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF);
    run_op("div neg by0", 1'b1, 1'b1, 32'h8765_4321, 32'd0, 32'h8765_4321, 32'hFFFF_FFFF);

    // start held high across the whole operation: exactly one launch
    bus.start = 1'b1; bus.op_div = 1'b0; bus.sign_op = 1'b0; bus.src1 = 32'd3; bus.src2 = 32'd5;
    tick();
    for (int k = 2; k <= 40; k++) begin
      tick();
      if (k >= 33) begin
        chk("hold done", 64'(bus.done), 64'(1));
        chk("hold lo", 64'(bus.lo), 64'(15));
      end else begin
        chk("hold busy", 64'(bus.busy), 64'(1));
      end
    end
    bus.ack = 1'b1; bus.op_div = 1'b1; bus.src1 = 32'd100; bus.src2 = 32'd7;
    tick();
    bus.ack = 1'b0;
    chk("ack+start idle done", 64'(bus.done), 64'(0));
    chk("ack+start idle busy", 64'(bus.busy), 64'(0));
    tick();
    chk("second capture", 64'(bus.busy), 64'(1));
    repeat (9) tick();
    bus.cancel = 1'b1; bus.start = 1'b0;
    tick();
    bus.cancel = 1'b0;
    chk("cancel busy", 64'(bus.busy), 64'(0));
    chk("cancel done", 64'(bus.done), 64'(0));
    chk("cancel hi", 64'(bus.hi), 64'(0));
    chk("cancel lo", 64'(bus.lo), 64'(15));
    for (int k = 0; k < 30; k++) begin
      tick();
      chk("cancel no done", 64'(bus.done), 64'(0));
      chk("cancel lo held", 64'(bus.lo), 64'(15));
    end

    // cancel and ack together in DONE keep the results
    bus.start = 1'b1; bus.op_div = 1'b0; bus.sign_op = 1'b1;
    bus.src1 = 32'hFFFF_FFFD; bus.src2 = 32'd7;
    tick();
    bus.start = 1'b0;
    repeat (32) tick();
    chk("c+a done", 64'(bus.done), 64'(1));
    bus.cancel = 1'b1; bus.ack = 1'b1;
    tick();
    bus.cancel = 1'b0; bus.ack = 1'b0;
    chk("c+a idle", 64'(bus.done), 64'(0));
    chk("c+a hi", 64'(bus.hi), 64'(32'hFFFF_FFFF));
    chk("c+a lo", 64'(bus.lo), 64'(32'hFFFF_FFEB));

    // reset at T+20
    bus.start = 1'b1; bus.op_div = 1'b0; bus.sign_op = 1'b0;
    bus.src1 = 32'hFFFF_FFFF; bus.src2 = 32'hFFFF_FFFF;
    tick();
    bus.start = 1'b0;
    repeat (19) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midreset busy", 64'(bus.busy), 64'(0));
    chk("midreset done", 64'(bus.done), 64'(0));
    chk("midreset hi", 64'(bus.hi), 64'(0));
    chk("midreset lo", 64'(bus.lo), 64'(0));
    tick();

    run_op("after reset", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
